// File: rtl/ga20_fetch_pkg.sv
// Shared types and constants for the GA20 sample fetch cache.
// Lines are 8 bytes wide to match one 64-bit SDRAM word.
package ga20_fetch_pkg;

    localparam int SAMPLE_ADDR_W = 20;
    localparam int LINE_BYTES    = 8;
    localparam int OFS_W         = 3;
    localparam int TAG_W         = SAMPLE_ADDR_W - OFS_W;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESPOND
    } fetch_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]          tag;
        logic                      valid;
        logic [8*LINE_BYTES-1:0]   data;
    } line_t;

    function automatic logic [7:0] pick_byte(input logic [8*LINE_BYTES-1:0] word,
                                             input logic [OFS_W-1:0]        ofs);
        return word[{ofs, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ga20_sample_fetch_if.sv
// GA20 sample-read port plus the shared SDRAM line-read port.
// slave is the fetch block's view; master is the GA20/SDRAM side.
interface ga20_sample_fetch_if
    import ga20_fetch_pkg::*;
#(
    parameter int ADDR_W = SAMPLE_ADDR_W
);
    logic                    flush;
    logic                    sample_rd;
    logic [ADDR_W-1:0]       sample_addr;
    logic                    sample_valid;
    logic [7:0]              sample_din;
    logic                    mem_req;
    logic [ADDR_W-OFS_W-1:0] mem_addr;
    logic                    mem_ack;
    logic [63:0]             mem_data;

    modport slave (
        input  flush, sample_rd, sample_addr, mem_ack, mem_data,
        output sample_valid, sample_din, mem_req, mem_addr
    );

    modport master (
        output flush, sample_rd, sample_addr, mem_ack, mem_data,
        input  sample_valid, sample_din, mem_req, mem_addr
    );
endinterface

// File: rtl/ga20_line_cache.sv
// Fully-associative line store: parallel tag compare, byte pick on hit,
// one write port for refills and a whole-cache invalidate.
module ga20_line_cache
    import ga20_fetch_pkg::*;
#(
    parameter  int LINES = 4,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [TAG_W-1:0]  lookup_tag,
    input  logic [OFS_W-1:0]  lookup_ofs,
    output logic              hit,
    output logic [7:0]        hit_byte,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  line_t             wr_line
);

    // Lines live in flops so compare and byte pick complete in the lookup cycle.
    line_t            lines_reg [LINES];
    logic [LINES-1:0] hit_vec;

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_cmp
            assign hit_vec[gi] = lines_reg[gi].valid && (lines_reg[gi].tag == lookup_tag);
        end
    endgenerate

    assign hit = |hit_vec;

    // Tags are unique, so OR-ing the masked bytes selects the single hit line.
    always_comb begin
        hit_byte = '0;
        for (int i = 0; i < LINES; i++) begin
            if (hit_vec[i]) begin
                hit_byte = hit_byte | pick_byte(lines_reg[i].data, lookup_ofs);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LINES; i++) begin
                lines_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    lines_reg[i] <= wr_line;
                end else if (flush) begin
                    lines_reg[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ga20_sample_fetch.sv
// GA20 sample fetch: request latch, lookup/refill FSM and SDRAM handshake
// in front of a small fully-associative line cache.
module ga20_sample_fetch
    import ga20_fetch_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int ADDR_W = SAMPLE_ADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    ga20_sample_fetch_if.slave bus
);

    localparam int IDX_W = $clog2(LINES);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  req_addr_reg, req_addr_next;
    logic               pending_reg, pending_next;
    logic               valid_reg, valid_next;
    logic [7:0]         din_reg, din_next;
    logic               mem_req_reg, mem_req_next;
    logic [TAG_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [TAG_W-1:0]   fill_tag_reg, fill_tag_next;
    logic [63:0]        fill_data_reg, fill_data_next;
    logic [IDX_W-1:0]   repl_ptr_reg, repl_ptr_next;
    logic               flush_seen_reg, flush_seen_next;

    logic               hit;
    logic [7:0]         hit_byte;
    logic               wr_en;
    line_t              wr_line;
    logic [TAG_W-1:0]   req_tag;

    assign req_tag = req_addr_reg[ADDR_W-1:OFS_W];

    // A flush in the ack cycle must also keep the incoming line invalid.
    assign wr_line = '{tag: fill_tag_reg, valid: !flush_seen_reg && !bus.flush, data: bus.mem_data};

    ga20_line_cache #(.LINES(LINES)) u_cache (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (bus.flush),
        .lookup_tag (req_tag),
        .lookup_ofs (req_addr_reg[OFS_W-1:0]),
        .hit        (hit),
        .hit_byte   (hit_byte),
        .wr_en      (wr_en),
        .wr_idx     (repl_ptr_reg),
        .wr_line    (wr_line)
    );

    always_comb begin
        state_next      = state_reg;
        req_addr_next   = req_addr_reg;
        pending_next    = pending_reg;
        valid_next      = valid_reg;
        din_next        = din_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        fill_tag_next   = fill_tag_reg;
        fill_data_next  = fill_data_reg;
        repl_ptr_next   = repl_ptr_reg;
        flush_seen_next = flush_seen_reg;
        wr_en           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pending_reg || bus.sample_rd) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    din_next     = hit_byte;
                    valid_next   = 1'b1;
                    pending_next = 1'b0;
                    state_next   = IDLE;
                end else begin
                    mem_addr_next = req_tag;
                    mem_req_next  = 1'b1;
                    fill_tag_next = req_tag;
                    state_next    = FILL;
                end
            end
            FILL: begin
                if (bus.flush) begin
                    flush_seen_next = 1'b1;
                end
                if (bus.mem_ack) begin
                    mem_req_next   = 1'b0;
                    wr_en          = 1'b1;
                    fill_data_next = bus.mem_data;
                    repl_ptr_next  = repl_ptr_reg + 1'b1;
                    state_next     = RESPOND;
                end
            end
            RESPOND: begin
                if (pending_reg && (req_tag == fill_tag_reg) && !flush_seen_reg) begin
                    din_next     = pick_byte(fill_data_reg, req_addr_reg[OFS_W-1:0]);
                    valid_next   = 1'b1;
                    pending_next = 1'b0;
                end
                flush_seen_next = 1'b0;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A new strobe overrides anything served this cycle: latest wins.
        if (bus.sample_rd) begin
            req_addr_next = bus.sample_addr;
            pending_next  = 1'b1;
            valid_next    = 1'b0;
            din_next      = din_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            req_addr_reg   <= '0;
            pending_reg    <= 1'b0;
            valid_reg      <= 1'b0;
            din_reg        <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            fill_tag_reg   <= '0;
            fill_data_reg  <= '0;
            repl_ptr_reg   <= '0;
            flush_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_addr_reg   <= req_addr_next;
            pending_reg    <= pending_next;
            valid_reg      <= valid_next;
            din_reg        <= din_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            fill_tag_reg   <= fill_tag_next;
            fill_data_reg  <= fill_data_next;
            repl_ptr_reg   <= repl_ptr_next;
            flush_seen_reg <= flush_seen_next;
        end
    end

    assign bus.sample_valid = valid_reg;
    assign bus.sample_din   = din_reg;
    assign bus.mem_req      = mem_req_reg;
    assign bus.mem_addr     = mem_addr_reg;

endmodule

// File: tb/tb_ga20_sample_fetch.sv
// Directed plus randomized bench for ga20_sample_fetch; the bench acts as
// the SDRAM and predicts hits with a FIFO-replacement cache model.
module tb_ga20_sample_fetch;

    localparam int LINES = 4;

    logic clk;
    logic reset_n;

    ga20_sample_fetch_if bus ();

    ga20_sample_fetch #(.LINES(LINES), .ADDR_W(20)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: resident lines, FIFO slot pointer, and backing memory.
    logic [16:0] m_tag [LINES];
    bit          m_val [LINES];
    int          m_ptr;
    logic [63:0] mem [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [16:0] line);
        if (!mem.exists(int'(line))) mem[int'(line)] = {$urandom, $urandom};
        return mem[int'(line)];
    endfunction

    function automatic bit m_hit(input logic [16:0] line);
        for (int i = 0; i < LINES; i++) if (m_val[i] && m_tag[i] == line) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [16:0] line, input bit keep);
        m_tag[m_ptr] = line;
        m_val[m_ptr] = keep;
        m_ptr = (m_ptr + 1) % LINES;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < LINES; i++) m_val[i] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_flush();
        m_ptr = 0;
    endfunction

    // Complete read: strobe, answer any memory request after ack_dly cycles, check result.
    task automatic do_read(input logic [19:0] addr, input int ack_dly, input bit with_flush,
                           output bit was_hit);
        logic [16:0] line;
        logic [63:0] w;
        logic [7:0]  exp_b;
        bit          exp_hit, seen, acked, got;
        int          cnt, lat;
        line  = addr[19:3];
        w     = word_of(line);
        exp_b = w[addr[2:0]*8 +: 8];
        if (with_flush) m_flush();
        exp_hit = m_hit(line);
        seen = 0; acked = 0; got = 0; cnt = 0; lat = 0;
        @(negedge clk);
        bus.sample_rd   = 1'b1;
        bus.sample_addr = addr;
        bus.flush       = with_flush;
        for (int c = 1; c <= 80 && !got; c++) begin
            @(negedge clk);
            bus.sample_rd = 1'b0;
            bus.flush     = 1'b0;
            bus.mem_ack   = 1'b0;
            if (c == 1) check("valid_clear", bus.sample_valid, 1'b0);
            if (bus.sample_valid) begin
                got = 1; lat = c;
            end else if (bus.mem_req && !acked) begin
                if (!seen) begin
                    seen = 1;
                    check("mem_addr", bus.mem_addr, line);
                    cnt = ack_dly;
                end
                if (cnt == 0) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = w;
                    acked = 1;
                end else begin
                    cnt--;
                end
            end
        end
        bus.mem_ack = 1'b0;
        if (!exp_hit) m_fill(line, 1'b1);
        was_hit = !seen;
        check("valid_seen", got, 1'b1);
        check("hit_miss", seen, !exp_hit);
        check("sample_din", bus.sample_din, exp_b);
        if (exp_hit) check("hit_latency", lat, 2);
        @(negedge clk);
        check("hold_valid", bus.sample_valid, 1'b1);
        check("hold_din", bus.sample_din, exp_b);
        $display("read addr=%05h line=%05h %s lat=%0d din=%02h exp=%02h",
                 addr, line, seen ? "miss" : "hit", lat, bus.sample_din, exp_b);
    endtask

    task automatic pulse_rd(input logic [19:0] a);
        @(negedge clk);
        bus.sample_rd   = 1'b1;
        bus.sample_addr = a;
        @(negedge clk);
        bus.sample_rd   = 1'b0;
    endtask

    task automatic wait_req(output bit ok, output bit vseen);
        ok = 0; vseen = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (bus.sample_valid) vseen = 1;
            if (bus.mem_req) ok = 1;
        end
    endtask

    task automatic send_ack(input logic [63:0] w);
        bus.mem_ack  = 1'b1;
        bus.mem_data = w;
        @(negedge clk);
        bus.mem_ack  = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int c = 0; c < 40 && !ok; c++) begin
            if (bus.sample_valid) ok = 1;
            else @(negedge clk);
        end
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        m_flush();
    endtask

    initial begin
        bit          h, ok, vseen;
        logic [63:0] w;
        logic [19:0] a;
        logic [16:0] pool [6];

        bus.flush = 0; bus.sample_rd = 0; bus.sample_addr = '0;
        bus.mem_ack = 0; bus.mem_data = '0;
        reset_n = 1'b0;
        m_reset();
        mem[32'h0246] = 64'h8877665544332211;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.sample_valid, 1'b0);
        check("rst_din", bus.sample_din, 8'h00);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 17'h0);
        reset_n = 1'b1;
        $display("reset released");

        // Cold miss, then hit in the same line
        do_read(20'h01234, 5, 1'b0, h);
        check("cold_miss", h, 1'b0);
        check("cold_din", bus.sample_din, 8'h55);
        do_read(20'h01237, 0, 1'b0, h);
        check("hit_same_line", h, 1'b1);
        check("hit_din", bus.sample_din, 8'h88);

        // Latest wins: second strobe arrives while the first line is filling
        pulse_rd(20'h00010);
        wait_req(ok, vseen);
        check("lw_req1", ok, 1'b1);
        check("lw_addr1", bus.mem_addr, 17'h00002);
        pulse_rd(20'h20008);
        send_ack(word_of(17'h00002));
        m_fill(17'h00002, 1'b1);
        wait_req(ok, vseen);
        check("lw_req2", ok, 1'b1);
        check("lw_no_stale_valid", vseen, 1'b0);
        check("lw_addr2", bus.mem_addr, 17'h04001);
        w = word_of(17'h04001);
        send_ack(w);
        m_fill(17'h04001, 1'b1);
        wait_valid(ok);
        check("lw_valid", ok, 1'b1);
        check("lw_din", bus.sample_din, w[7:0]);
        $display("latest-wins din=%02h exp=%02h", bus.sample_din, w[7:0]);
        do_read(20'h00014, 2, 1'b0, h);
        check("lw_first_line_kept", h, 1'b1);

        // Replacement after five distinct misses
        do_flush();
        for (int k = 0; k < 5; k++) begin
            do_read(20'h30000 + 20'(k * 8), 1, 1'b0, h);
            check("repl_fill_miss", h, 1'b0);
        end
        do_read(20'h30008, 1, 1'b0, h);
        check("repl_second_hits", h, 1'b1);
        do_read(20'h30000, 1, 1'b0, h);
        check("repl_first_evicted", h, 1'b0);

        // Flush together with a strobe: the read must miss
        do_read(20'h30013, 1, 1'b1, h);
        check("flush_rd_miss", h, 1'b0);

        // Flush during fill: refill discarded, the same line is requested again
        pulse_rd(20'h05555);
        wait_req(ok, vseen);
        check("ff_req1", ok, 1'b1);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        m_flush();
        w = word_of(17'h00AAA);
        send_ack(w);
        m_fill(17'h00AAA, 1'b0);
        wait_req(ok, vseen);
        check("ff_rerequest", ok, 1'b1);
        check("ff_no_valid", vseen, 1'b0);
        check("ff_addr", bus.mem_addr, 17'h00AAA);
        send_ack(w);
        m_fill(17'h00AAA, 1'b1);
        wait_valid(ok);
        check("ff_valid", ok, 1'b1);
        check("ff_din", bus.sample_din, w[47:40]);
        $display("flush-during-fill din=%02h exp=%02h", bus.sample_din, w[47:40]);

        // Asynchronous reset in the middle of a fill
        do_read(20'h0ABCD, 0, 1'b0, h);
        pulse_rd(20'h7FFF8);
        wait_req(ok, vseen);
        check("ar_req", ok, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_mem_req", bus.mem_req, 1'b0);
        check("ar_valid", bus.sample_valid, 1'b0);
        check("ar_din", bus.sample_din, 8'h00);
        check("ar_mem_addr", bus.mem_addr, 17'h0);
        $display("async reset mid-fill mem_req=%0b valid=%0b", bus.mem_req, bus.sample_valid);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        do_read(20'h0ABCD, 1, 1'b0, h);
        check("ar_reread_miss", h, 1'b0);

        // Randomized reads over six lines, so four slots keep evicting
        for (int k = 0; k < 6; k++) pool[k] = 17'h01000 + 17'(k * 19);
        for (int n = 0; n < 40; n++) begin
            a = {pool[$urandom_range(0, 5)], 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) == 0) do_flush();
            do_read(a, $urandom_range(0, 4), ($urandom_range(0, 7) == 0), h);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
